handshake_cmpi_fifo: RTL
========================

HANDSHAKE_CMPI_FIFO -- requirements
Module: handshake_cmpi_fifo

Interface
REQ-001 Parameter DATA_TYPE, default 32, SHALL set the operand width in bits (legal range 1..64).
REQ-002 Parameter PREDICATE, default 5, SHALL select the compare: 0 eq, 1 ne, 2 slt, 3 sle, 4 sgt, 5 sge, 6 ult, 7 ule, 8 ugt, 9 uge.
REQ-003 Parameter DEPTH, default 2, SHALL set the number of result entries held (legal range 1..16).
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-006 Port lhs, input, DATA_TYPE bits, SHALL be the left operand.
REQ-007 Port lhs_valid, input, 1 bit, SHALL flag lhs as valid.
REQ-008 Port rhs, input, DATA_TYPE bits, SHALL be the right operand.
REQ-009 Port rhs_valid, input, 1 bit, SHALL flag rhs as valid.
REQ-010 Port result_ready, input, 1 bit, SHALL indicate that downstream accepts result.
REQ-011 Port result, output, 1 bit, SHALL carry the head entry's compare outcome.
REQ-012 Port result_valid, output, 1 bit, SHALL flag result as valid.
REQ-013 Ports lhs_ready and rhs_ready, outputs, 1 bit each, SHALL signal operand consumption.
REQ-014 Port occupancy, output, clog2(DEPTH+1) bits, SHALL report the number of stored entries.

Function
REQ-015 The compare SHALL use the selected predicate over the full DATA_TYPE width: two's-complement for s*, zero-extended magnitude for u*, and bitwise equality for eq/ne.
REQ-016 A PREDICATE outside 0..9 SHALL stop elaboration with an error.
REQ-017 The not-full condition SHALL be defined as occupancy < DEPTH.
REQ-018 The input join SHALL follow these rules:
- lhs_ready = rhs_valid & not-full.
- rhs_ready = lhs_valid & not-full.
- push = lhs_valid & rhs_valid & not-full.
REQ-019 The ready outputs SHALL NOT depend combinationally on result_ready.
REQ-020 On push, the compare outcome SHALL be written at the tail of a circular buffer in the same edge.
REQ-021 Result outputs SHALL be driven as follows:
- result_valid = (occupancy != 0).
- result = the head entry.
- Both are driven from registers or the storage array, with no combinational path from lhs or rhs.
REQ-022 Pop SHALL equal result_valid & result_ready, and pop advances the head on the next edge.
REQ-023 Latency SHALL be exactly 1 cycle: a pair pushed at edge N appears on result at cycle N+1 when the buffer was empty; there is no bypass.
REQ-024 Occupancy SHALL update per cycle as follows:
- Push alone increments it.
- Pop alone decrements it.
- Simultaneous push and pop leaves it unchanged.
REQ-025 When full (occupancy == DEPTH), a pop SHALL NOT enable a push in the same cycle; both ready outputs stay 0 that cycle.
REQ-026 Head and tail pointers SHALL wrap from DEPTH-1 to 0, including when DEPTH is not a power of two.
REQ-027 Results SHALL leave in strict arrival order, with no loss or duplication.
REQ-028 While result_valid = 1 and result_ready = 0, result SHALL hold stable.
REQ-029 If only one operand is valid, no push SHALL occur, and that operand's ready output remains 0.
REQ-030 When DEPTH = 1, throughput SHALL be at most one result per 2 cycles.
REQ-031 When DEPTH >= 2 with result_ready held at 1, throughput SHALL be one result per cycle.

Reset
REQ-032 When rst = 1 at a rising edge, occupancy, head and tail SHALL become 0 and all stored entries SHALL be discarded, including in-flight entries during mid-operation.
REQ-033 While rst = 1, the outputs SHALL be: result_valid = 0, result = 0, lhs_ready = 0, rhs_ready = 0, occupancy = 0.
REQ-034 In the cycle during which rst is asserted, push and pop SHALL be suppressed.
REQ-035 In the first cycle after rst deasserts, lhs_ready SHALL equal rhs_valid.

Verification
REQ-036 The bench SHALL cover: DATA_TYPE=8, PREDICATE=5, lhs=0x80, rhs=0x01, both valid, result_ready=1 -> result=0 with result_valid=1 exactly 1 cycle later.
REQ-037 The bench SHALL cover: the same operands with PREDICATE=9 -> result=1; with PREDICATE=0 on lhs=rhs=0xA5 -> result=1.
REQ-038 The bench SHALL cover: DEPTH=2, result_ready=0, three back-to-back valid pairs -> two pushes, occupancy=2, ready outputs 0 on the third cycle; then result_ready=1 -> results drain in order, and the third pair is accepted only after occupancy < 2.
REQ-039 The bench SHALL cover: lhs_valid=1, rhs_valid=0 for 5 cycles -> lhs_ready=0, rhs_ready=1, occupancy=0 throughout.
REQ-040 The bench SHALL cover: DEPTH=3, 10 random pairs with random result_ready -> output sequence matches a reference model in order, pointers wrap correctly.
REQ-041 The bench SHALL cover: rst asserted for 1 cycle with occupancy=2 -> the next cycle shows occupancy=0 and result_valid=0, and no stale result ever appears.

Source files
------------

// File: rtl/handshake_cmpi_fifo.sv
// Integer compare of two joined operand streams, with results queued in a
// small circular buffer. Results leave one cycle after acceptance, in order.
module handshake_cmpi_fifo #(
  parameter int DATA_TYPE = 32,
  parameter int PREDICATE = 5,
  parameter int DEPTH     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_TYPE-1:0]         lhs,
  input  logic                         lhs_valid,
  input  logic [DATA_TYPE-1:0]         rhs,
  input  logic                         rhs_valid,
  input  logic                         result_ready,
  output logic                         result,
  output logic                         result_valid,
  output logic                         lhs_ready,
  output logic                         rhs_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (PREDICATE < 0 || PREDICATE > 9) begin : g_bad_pred
    $error("handshake_cmpi_fifo: PREDICATE %0d is not in 0..9", PREDICATE);
  end
  if (DATA_TYPE < 1 || DATA_TYPE > 64) begin : g_bad_width
    $error("handshake_cmpi_fifo: DATA_TYPE %0d is not in 1..64", DATA_TYPE);
  end
  if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
    $error("handshake_cmpi_fifo: DEPTH %0d is not in 1..16", DEPTH);
  end

  // Storage is sized to the pointer range so every pointer value indexes a real bit.
  logic [(1<<PTR_W)-1:0] mem;
  logic [PTR_W-1:0]      head, tail;
  logic [OCC_W-1:0]      occ;
  logic                  cmp, not_full, push, pop;

  always_comb begin
    cmp = 1'b0;
    case (PREDICATE)
      0:       cmp = (lhs == rhs);
      1:       cmp = (lhs != rhs);
      2:       cmp = ($signed(lhs) <  $signed(rhs));
      3:       cmp = ($signed(lhs) <= $signed(rhs));
      4:       cmp = ($signed(lhs) >  $signed(rhs));
      5:       cmp = ($signed(lhs) >= $signed(rhs));
      6:       cmp = (lhs <  rhs);
      7:       cmp = (lhs <= rhs);
      8:       cmp = (lhs >  rhs);
      9:       cmp = (lhs >= rhs);
      default: cmp = 1'b0;
    endcase
  end

  // Full blocks the join even when a pop is pending: ready never sees result_ready.
  assign not_full     = (occ < OCC_W'(DEPTH));
  assign push         = !rst && lhs_valid && rhs_valid && not_full;
  assign lhs_ready    = !rst && rhs_valid && not_full;
  assign rhs_ready    = !rst && lhs_valid && not_full;
  assign result_valid = !rst && (occ != '0);
  assign pop          = result_valid && result_ready;
  assign result       = result_valid & mem[head];
  assign occupancy    = rst ? '0 : occ;

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      mem  <= '0;
    end else begin
      if (push) begin
        mem[tail] <= cmp;
        tail      <= (tail == PTR_W'(DEPTH-1)) ? '0 : tail + PTR_W'(1);
      end
      if (pop)
        head <= (head == PTR_W'(DEPTH-1)) ? '0 : head + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end
endmodule
